clz_seq_ctrl: RTL
=================

# clz_seq_ctrl

Multi-cycle sequencer for the CPU's count-leading-zeros/ones instructions (CLZ, CLO). It shares one 16-bit leading-zero counter across the two halves of a 32-bit operand, examining the high half first and the low half only when needed. It sits beside the ALU in the execute stage and exposes a start/busy/done handshake so the pipeline controller can stall while a count is in progress.

## Interface
- No parameters; operand width fixed at 32, result width fixed at 6.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request a count; sampled only in IDLE or DONE.
- op_clo  input  1  0 = CLZ (count leading zeros), 1 = CLO (count leading ones); sampled with start.
- rs  input  32  operand; sampled with start.
- flush  input  1  abort the operation in progress (pipeline flush).
- busy  output  1  high in HI and LO states.
- done  output  1  one-cycle pulse in DONE state; rd valid.
- rd  output  6  result register, 0..32; holds its value until the next completion or reset.

## Operation
- States: IDLE, HI, LO, DONE. Reset state IDLE.
- Operand register opr[31:0] is loaded on accepted start with rs (CLZ) or ~rs (CLO), so both ops reduce to a leading-zero count.
- Single shared function cnt16(x[15:0]) returns 0..16; 16 means x == 0. It is the only counting logic and is fed by a mux: opr[31:16] in HI, opr[15:0] in LO.
- IDLE: start=1 -> load opr, go HI; else stay.
- HI: c = cnt16(opr[31:16]). If c < 16 -> rd <= {1'b0,c[4:0]}, go DONE. If c == 16 -> go LO.
- LO: c = cnt16(opr[15:0]); rd <= 16 + c (so all-zero operand gives 32 = 6'h20); go DONE.
- DONE: done=1. start=1 -> load opr, go HI (back-to-back). Otherwise go IDLE.
- start in HI or LO is ignored (no queueing). The requester holds its request until done.
- flush=1 in HI or LO -> go IDLE next edge; rd unchanged; no done pulse. flush in IDLE/DONE has no effect other than suppressing acceptance of a start in the same cycle (flush has priority over start).
- rst has priority over everything: state IDLE, opr=0, rd=0.
- Arithmetic: 16 + c computed in 6 bits, no overflow possible (max 32). rd[5]=1 only for the value 32.

## Timing
- Reset values: busy=0, done=0, rd=6'd0, state IDLE.
- Start accepted at edge k. busy=1 from edge k.
- High-half hit: DONE entered at edge k+1. done and new rd are visible in the cycle after edge k+1, for a latency of 2 cycles from the start cycle.
- Low-half path: DONE at edge k+2, for a latency of 3 cycles.
- done lasts exactly one cycle. rd updates on the same edge that enters DONE.
- Back-to-back throughput: a start during the DONE cycle is accepted, giving one result every 2 (hi) or 3 (lo) cycles.
- busy and done are registered-state decodes, so there is no combinational path from start to busy. The pipeline stall must be derived externally as start | busy.
- rst asserted mid-operation: next cycle is IDLE with outputs at reset values, and the pending result is discarded.

## Test plan
- CLZ rs=32'h0001_0000 -> high-half path, done 2 cycles after start, rd=15. CLZ rs=32'h8000_0000 -> rd=0.
- CLZ rs=32'h0000_8000 -> busy for 2 cycles, done 3 cycles after start, rd=16. CLZ rs=0 -> rd=32. CLZ rs=1 -> rd=31.
- CLO rs=32'hF000_0000 -> rd=4. CLO rs=32'hFFFF_FFFF -> rd=32. CLO rs=32'hFFFF_7FFF -> rd=16. CLO rs=32'h7FFF_FFFF -> rd=0.
- Start CLZ 0x0000_00FF and assert flush in the LO cycle -> IDLE next cycle, no done, rd keeps its previous value (e.g. 4 from the prior op).
- Start CLZ 0x0000_0001, pulse start with rs=0x8000_0000 during HI (ignored) -> rd=31. Then start CLZ 0x0010_0000 in the DONE cycle -> accepted, rd=11 after 2 more cycles.
- Assert rst during HI of a count with rd previously 7 -> next cycle busy=0, done=0, rd=0. A fresh start then completes normally.

Source files
------------

// File: rtl/clz_seq_ctrl_if.sv
// Request/response bundle between the pipeline controller and the CLZ/CLO sequencer.
// The master side issues start/op_clo/rs/flush and observes busy/done/rd.
interface clz_seq_ctrl_if;
    logic        start;
    logic        op_clo;
    logic [31:0] rs;
    logic        flush;
    logic        busy;
    logic        done;
    logic [5:0]  rd;

    modport master (
        output start, op_clo, rs, flush,
        input  busy, done, rd
    );

    modport slave (
        input  start, op_clo, rs, flush,
        output busy, done, rd
    );
endinterface

// File: rtl/clz_seq_ctrl.sv
// Count leading zeros/ones of a 32-bit operand using one shared 16-bit counter: 2 cycles (high-half hit) or 3 (low half).
// No backpressure: start is only accepted in IDLE/DONE; stall externally on start | busy; flush aborts without a done pulse.
module clz_seq_ctrl (
    input  logic           clk,
    input  logic           rst,
    clz_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] opr;
    logic [31:0] opr_nxt;
    logic [5:0]  rd_q;
    logic [5:0]  rd_nxt;
    logic [15:0] half;
    logic [4:0]  cnt;

    // Leading-zero count of a 16-bit value; returns 16 when the value is zero.
    function automatic logic [4:0] cnt16(input logic [15:0] x);
        logic [4:0] n;
        logic       found;
        n     = 5'd16;
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!found && x[i]) begin
                n     = 5'(15 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    assign half = (state == LO) ? opr[15:0] : opr[31:16];
    assign cnt  = cnt16(half);

    always_comb begin
        state_nxt = state;
        opr_nxt   = opr;
        rd_nxt    = rd_q;
        unique case (state)
            IDLE, DONE: begin
                // flush outranks start, so a start in a flush cycle is dropped
                if (bus.start && !bus.flush) begin
                    opr_nxt   = bus.op_clo ? ~bus.rs : bus.rs;
                    state_nxt = HI;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HI: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (!cnt[4]) begin
                    rd_nxt    = {1'b0, cnt};
                    state_nxt = DONE;
                end else begin
                    state_nxt = LO;
                end
            end
            LO: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else begin
                    rd_nxt    = 6'd16 + {1'b0, cnt};
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opr   <= 32'd0;
            rd_q  <= 6'd0;
        end else begin
            state <= state_nxt;
            opr   <= opr_nxt;
            rd_q  <= rd_nxt;
        end
    end

    assign bus.busy = (state == HI) || (state == LO);
    assign bus.done = (state == DONE);
    assign bus.rd   = rd_q;

endmodule
